// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
package ps2_pkg;

  // An 11-bit device-to-host frame: start, 8 data bits LSB first, odd parity, stop.
  localparam int PS2_FRAME_BITS = 11;
  localparam int START_BIT      = 0;
  localparam int PARITY_BIT     = 9;
  localparam int STOP_BIT       = 10;

  // Width of the bit counter that walks through one frame (0..10).
  localparam int PS2_CNT_W = $clog2(PS2_FRAME_BITS);

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/ps2_rx_fifo.sv
// Byte FIFO for received scan codes. Pointers carry an extra wrap bit so all
// DEPTH entries are usable. A pop in the same cycle as a push on a full FIFO
// frees the slot first, so that push is accepted.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  clk,
  input  logic  clrn,
  input  logic  push,
  input  byte_t push_data,
  input  logic  pop,
  output byte_t rd_data,
  output logic  full,
  output logic  empty,
  output logic  push_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] w_ptr;
  logic [AW:0] r_ptr;
  byte_t       mem [DEPTH];
  logic        pop_ok;
  logic        push_ok;

  // Status flags and accepted-operation qualifiers.
  always_comb begin
    empty     = (w_ptr == r_ptr);
    full      = (w_ptr[AW-1:0] == r_ptr[AW-1:0]) && (w_ptr[AW] != r_ptr[AW]);
    pop_ok    = pop && !empty;
    push_ok   = push && (!full || pop_ok);
    push_drop = push && full && !pop_ok;
    rd_data   = mem[r_ptr[AW-1:0]];
  end

  // Read and write pointers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      if (push_ok) w_ptr <= w_ptr + 1'b1;
      if (pop_ok)  r_ptr <= r_ptr + 1'b1;
    end
  end

  // Storage, cleared on reset so the head reads 8'h00 afterwards.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[w_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 device-to-host receiver: synchronises the raw PS/2 lines, deframes
// 11-bit frames, validates start/parity/stop and queues good bytes.
//
// Consumer handshake: data is meaningful only while ready=1. A byte is
// consumed at every rising clk edge where nextdata_n=0 and ready=1; holding
// nextdata_n low pops one byte per cycle. nextdata_n=0 with ready=0 is ignored.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic  clk,
  input  logic  clrn,
  input  logic  ps2_clk,
  input  logic  ps2_data,
  input  logic  nextdata_n,
  output byte_t data,
  output logic  ready,
  output logic  overflow
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]                clk_sync;
  logic [1:0]                data_sync;
  logic                      strobe;
  logic [PS2_CNT_W-1:0]      count;
  logic [PARITY_BIT:START_BIT] buffer;
  logic [TW-1:0]             timer;
  logic                      timeout_hit;
  logic                      frame_valid;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      push_drop;
  logic                      pop_fire;

  // Synchronisers: ps2_clk through three flops (idle high), ps2_data through two.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Falling-edge strobe, frame check on the stop bit, timeout and pop qualifiers.
  always_comb begin
    strobe      = clk_sync[2] && !clk_sync[1];
    frame_valid = strobe && (count == PS2_CNT_W'(STOP_BIT)) &&
                  !buffer[START_BIT] && data_sync[1] &&
                  (^buffer[PARITY_BIT:START_BIT+1]);
    timeout_hit = (count != '0) && !strobe && (timer == TW'(TIMEOUT_CYCLES - 1));
    pop_fire    = !nextdata_n && !fifo_empty;
  end

  // Bit counter and shift buffer; the stop bit is checked directly, not stored.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      count  <= '0;
      buffer <= '0;
    end else if (strobe) begin
      if (count == PS2_CNT_W'(STOP_BIT)) begin
        count <= '0;
      end else begin
        buffer[count] <= data_sync[1];
        count         <= count + 1'b1;
      end
    end else if (timeout_hit) begin
      count <= '0;
    end
  end

  // Idle timer: runs only inside a frame, restarts on every strobe.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      timer <= '0;
    end else if (strobe || (count == '0) || timeout_hit) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Sticky overflow: set when a good byte is dropped, cleared by a real pop.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      overflow <= 1'b0;
    end else if (pop_fire) begin
      overflow <= 1'b0;
    end else if (push_drop) begin
      overflow <= 1'b1;
    end
  end

  ps2_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clrn      (clrn),
    .push      (frame_valid),
    .push_data (buffer[8:1]),
    .pop       (!nextdata_n),
    .rd_data   (data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .push_drop (push_drop)
  );

  // Consumer-visible status.
  always_comb begin
    ready = !fifo_empty;
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Bench for ps2_keyboard: directed scenarios plus randomised frames/pops,
// checked each cycle against a queue-based model of the receiver.
module tb_ps2_keyboard;
  import ps2_pkg::*;

  localparam int DEPTH = 8;
  localparam int TO    = 200;
  localparam int HALF  = 20;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;

  ps2_keyboard #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  bit          exp_ov = 0;
  int unsigned cyc = 0;
  logic [7:0]  pend_b[$];
  int unsigned pend_t[$];
  bit          fr_bits[$];
  int unsigned last_fall = 0;
  bit          chk_en = 0;
  bit          rnd_done = 0;
  int          pop_rate = 16;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_clear();
    exp_q.delete();
    exp_ov = 0;
    pend_b.delete();
    pend_t.delete();
    fr_bits.delete();
  endfunction

  // Called at every falling PS/2 clock edge the bench drives.
  function automatic void model_fall(input bit b);
    logic [7:0] v;
    int ones;
    if (fr_bits.size() != 0 && (cyc - last_fall) > TO) fr_bits.delete();
    last_fall = cyc;
    fr_bits.push_back(b);
    if (fr_bits.size() == 11) begin
      ones = 0;
      for (int i = 1; i <= 8; i++) v[i-1] = fr_bits[i];
      for (int i = 1; i <= 9; i++) ones += int'(fr_bits[i]);
      if (fr_bits[0] == 1'b0 && fr_bits[10] == 1'b1 && (ones % 2) == 1) begin
        // two synchroniser flops, then the strobe cycle registers the byte
        pend_b.push_back(v);
        pend_t.push_back(cyc + 3);
      end
      fr_bits.delete();
    end
  endfunction

  // Model update at each rising edge: pop first, then any due push.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (clrn) begin
        if (!nextdata_n && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          exp_ov = 0;
        end
        while (pend_t.size() > 0 && pend_t[0] == cyc) begin
          void'(pend_t.pop_front());
          if (exp_q.size() < DEPTH) exp_q.push_back(pend_b.pop_front());
          else begin
            void'(pend_b.pop_front());
            exp_ov = 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison on the falling clk edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("ready", ready, exp_q.size() != 0);
        check("overflow", overflow, exp_ov);
        if (exp_q.size() != 0) check("data", data, exp_q[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input bit b, input bit pop_here);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF - 1) @(negedge clk);
    ps2_clk = 1'b0;
    model_fall(b);
    if (pop_here) begin
      @(negedge clk);
      @(negedge clk);
      nextdata_n = 1'b0;
      @(negedge clk);
      nextdata_n = 1'b1;
      repeat (HALF - 3) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2_clk = 1'b1;
  endtask

  // kind: 0 valid, 1 bad parity, 2 bad stop, 3 bad start
  function automatic logic [10:0] make_frame(input logic [7:0] b, input int kind);
    logic [10:0] f;
    f = {1'b1, ~^b, b, 1'b0};
    if (kind == 1) f[9]  = ~f[9];
    if (kind == 2) f[10] = 1'b0;
    if (kind == 3) f[0]  = 1'b1;
    return f;
  endfunction

  task automatic send_frame(input logic [7:0] b, input int kind, input bit pop_at_stop);
    logic [10:0] f;
    f = make_frame(b, kind);
    for (int i = 0; i < 11; i++) send_bit(f[i], pop_at_stop && (i == 10));
  endtask

  task automatic send_partial(input logic [7:0] b, input int n);
    logic [10:0] f;
    f = make_frame(b, 0);
    for (int i = 0; i < n; i++) send_bit(f[i], 1'b0);
  endtask

  task automatic pop_one();
    @(negedge clk);
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2 clrn = 1'b0;
    model_clear();
    #1;
    check("rst_ready", ready, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_data", data, 8'h00);
    repeat (3) @(negedge clk);
    #2 clrn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    #2 clrn = 1'b1;
    model_clear();
    chk_en = 1;
    @(negedge clk);
    check("init_ready", ready, 1'b0);
    check("init_overflow", overflow, 1'b0);
    check("init_data", data, 8'h00);

    // single valid byte
    send_frame(8'h1C, 0, 0);
    @(negedge clk);
    check("lit_1c_ready", ready, 1'b1);
    check("lit_1c_data", data, 8'h1C);
    pop_one();
    check("lit_1c_popped", ready, 1'b0);

    // bad parity and bad stop dropped, then a good byte
    send_frame(8'h1C, 1, 0);
    send_frame(8'h1C, 2, 0);
    @(negedge clk);
    check("lit_bad_ready", ready, 1'b0);
    check("lit_bad_overflow", overflow, 1'b0);
    send_frame(8'hF0, 0, 0);
    @(negedge clk);
    check("lit_f0_data", data, 8'hF0);
    pop_one();

    // back-to-back bytes come out in order
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    send_frame(8'hE0, 0, 0);
    @(negedge clk); check("lit_seq0", data, 8'hF0); pop_one();
    check("lit_seq1", data, 8'h1C); pop_one();
    check("lit_seq2", data, 8'hE0); pop_one();
    check("lit_seq_empty", ready, 1'b0);

    // overflow on the ninth byte
    for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 0, 0);
    @(negedge clk);
    check("lit_ovf_set", overflow, 1'b1);
    for (int i = 1; i <= DEPTH; i++) begin
      check("lit_ovf_data", data, 8'(i));
      pop_one();
      if (i == 1) check("lit_ovf_cleared", overflow, 1'b0);
    end
    check("lit_ovf_empty", ready, 1'b0);

    // pop and push together on a full FIFO: push accepted, no overflow
    for (int i = 0; i < DEPTH; i++) send_frame(8'h10 + 8'(i), 0, 0);
    send_frame(8'h18, 0, 1);
    @(negedge clk);
    check("lit_simul_ovf", overflow, 1'b0);
    for (int i = 1; i <= DEPTH; i++) begin
      check("lit_simul_data", data, 8'h10 + 8'(i));
      pop_one();
    end
    check("lit_simul_empty", ready, 1'b0);

    // partial frame discarded by the timeout
    send_partial(8'h2A, 5);
    repeat (TO + 100) @(negedge clk);
    send_frame(8'h2A, 0, 0);
    @(negedge clk);
    check("lit_to_data", data, 8'h2A);
    check("lit_to_overflow", overflow, 1'b0);
    pop_one();
    check("lit_to_empty", ready, 1'b0);

    // reset mid-frame
    send_partial(8'h77, 5);
    reset_pulse();
    send_frame(8'h55, 0, 0);
    @(negedge clk);
    check("lit_rst1_data", data, 8'h55);
    pop_one();

    // reset while ready=1 and overflow=1
    for (int i = 0; i <= DEPTH; i++) send_frame(8'h30 + 8'(i), 0, 0);
    @(negedge clk);
    check("lit_rst2_pre_ovf", overflow, 1'b1);
    reset_pulse();
    send_frame(8'h55, 0, 0);
    @(negedge clk);
    check("lit_rst2_data", data, 8'h55);
    pop_one();

    // randomised frames with a concurrent random consumer
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          int kind;
          pop_rate = (k < 20) ? 400 : 12;
          kind = $urandom_range(0, 9);
          if (kind <= 5) send_frame(8'($urandom_range(0, 255)), 0, 0);
          else if (kind <= 8) send_frame(8'($urandom_range(0, 255)), kind - 5, 0);
          else begin
            send_partial(8'($urandom_range(0, 255)), $urandom_range(1, 10));
            repeat (TO + 50) @(negedge clk);
          end
          repeat ($urandom_range(0, 60)) @(negedge clk);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          nextdata_n = ($urandom_range(0, pop_rate - 1) == 0) ? 1'b0 : 1'b1;
        end
        nextdata_n = 1'b1;
      end
    join

    // drain
    @(negedge clk);
    nextdata_n = 1'b0;
    repeat (2 * DEPTH) @(negedge clk);
    nextdata_n = 1'b1;
    @(negedge clk);
    check("drain_empty", ready, 1'b0);
    check("drain_overflow", overflow, 1'b0);

    repeat (5) @(negedge clk);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
